// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package fetch_unit_pkg;

    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding fetched words with their PCs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int FIFO_DEPTH = 2,
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [31:0]       push_data,
    input  logic [31:0]       push_pc,
    input  logic              pop,
    output logic [31:0]       head_data,
    output logic [31:0]       head_pc,
    output logic [CNT_W-1:0]  count
);

    logic [31:0]      data_mem [FIFO_DEPTH];
    logic [31:0]      pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr_q] <= push_data;
            pc_mem[wr_ptr_q]   <= push_pc;
        end
    end

    assign head_data = data_mem[rd_ptr_q];
    assign head_pc   = pc_mem[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order memory requests, buffers responses, drops stale ones after redirects.
// Optional macro FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_misaligned
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      head_data, head_pc;
    logic [SUM_W-1:0] inflight;
    logic             req_fire;
    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      redirect_target;

    // Tracks the PC of each live request so the response can be tagged on push.
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [31:0]      tag_mem [FIFO_DEPTH];
    logic [$clog2(FIFO_DEPTH+1)-1:0] unused_cnt;

    assign redirect_target = redirect_pc & PC_ALIGN_MASK;
    assign inflight = SUM_W'(fifo_count) + SUM_W'(live_q) + SUM_W'(drop_count_q);
    assign inst_valid = (fifo_count != '0);
    assign fifo_pop   = inst_valid & inst_ready;
    assign inst       = inst_valid ? head_data : INST_NOP;
    assign inst_pc    = inst_valid ? head_pc : 32'h0;
    assign imem_req_addr = fetch_pc_q;

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  imem_req_valid = (inflight < SUM_W'(FIFO_DEPTH));
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) state_d = ST_HALT;
`endif
    end

    always_comb begin
        req_fire     = imem_req_valid & imem_req_ready;
        fifo_push    = imem_rsp_valid && (drop_count_q == '0) && !redirect_valid;
        fetch_pc_d   = req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
        live_d       = live_q;
        drop_count_d = drop_count_q;
        if (redirect_valid) begin
            // Everything still in flight, including this cycle's request, becomes stale.
            fetch_pc_d   = redirect_target;
            live_d       = '0;
            drop_count_d = drop_count_q + live_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        end else begin
            if (imem_rsp_valid && (drop_count_q != '0)) drop_count_d = drop_count_q - CNT_W'(1);
            live_d = live_q + CNT_W'(req_fire) - CNT_W'(fifo_push);
        end
    end

    // Response PC is the oldest live request PC: fetch_pc minus the live count.
    always_comb begin
        rsp_pc_d = fetch_pc_q - (32'(live_q) << 2);
    end
    assign rsp_pc_q   = rsp_pc_d;
    assign unused_cnt = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= RESET_PC;
            live_q       <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            live_q       <= live_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fetch_misaligned_q, fetch_misaligned_d;
    always_comb begin
        fetch_misaligned_d = fetch_misaligned_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) fetch_misaligned_d = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_misaligned_q <= 1'b0;
        else     fetch_misaligned_q <= fetch_misaligned_d;
    end
    assign fetch_misaligned = fetch_misaligned_q;
`else
    assign fetch_misaligned = 1'b0;
`endif

    fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (imem_rsp_data),
        .push_pc   (rsp_pc_q),
        .pop       (fifo_pop),
        .head_data (head_data),
        .head_pc   (head_pc),
        .count     (fifo_count)
    );

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (drop_count_q == '0) && (fifo_count == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural in-order memory of configurable latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_misaligned;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    int          cycle = 0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < int'(q.size())) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        fire, popped, rsp;
        logic [31:0] faddr;
        exp_t        e;
        @(negedge clk);
        fire   = imem_req_valid & imem_req_ready;
        faddr  = imem_req_addr;
        popped = inst_valid & inst_ready;
        rsp    = imem_rsp_valid;
        if (popped && !rst) begin
            pop_log.push_back(inst_pc);
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_pop", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_inst_pc", inst_pc, e.pc);
                check_eq("sb_inst", inst, e.data);
            end
        end
        if (rsp) void'(mem_q.pop_front());
        if (fire) begin
            req_log.push_back(faddr);
            mem_q.push_back('{addr: faddr, due: cycle + lat});
        end
        if (redirect_valid) exp_q.delete();
        else if (fire) exp_q.push_back('{pc: faddr, data: mdata(faddr)});
        @(posedge clk);
        #1;
        cycle++;
        imem_rsp_valid = (mem_q.size() > 0) && (mem_q[0].due <= cycle);
        imem_rsp_data  = (mem_q.size() > 0) ? mdata(mem_q[0].addr) : 32'h0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mem_q.delete();
        exp_q.delete();
    endtask

    task automatic release_reset();
        run(2);
        req_log.delete();
        pop_log.delete();
        rst = 1'b0;
        #1;
        check_eq("boot_no_req", 32'(imem_req_valid), 32'h0);
        step();
        check_eq("run_req_valid", 32'(imem_req_valid), 32'h1);
        check_eq("run_req_addr", imem_req_addr, 32'h0);
    endtask

    task automatic wait_two_outstanding(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!imem_req_valid && mem_q.size() == 2) break;
            step();
        end
        check_eq(tag, 32'(mem_q.size()), 32'h2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        check_eq({tag, "_req_addr"}, imem_req_addr, 32'h0);
        check_eq({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
        check_eq({tag, "_inst"}, inst, 32'h0000_0013);
        check_eq({tag, "_inst_pc"}, inst_pc, 32'h0);
        check_eq({tag, "_misaligned"}, 32'(fetch_misaligned), 32'h0);
    endtask

    initial begin
        int np, nr;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        assert_reset();
        release_reset();

        // Streaming fetch, latency 1
        lat = 1;
        run(12);
        check_eq("t1_req0", at(req_log, 0), 32'h0);
        check_eq("t1_req1", at(req_log, 1), 32'h4);
        check_eq("t1_req2", at(req_log, 2), 32'h8);
        check_eq("t1_pc0", at(pop_log, 0), 32'h0);
        check_eq("t1_pc1", at(pop_log, 1), 32'h4);
        check_eq("t1_pc2", at(pop_log, 2), 32'h8);

        // Decoder stalled: fetch stops at buffer depth, then resumes
        assert_reset();
        inst_ready = 1'b0;
        release_reset();
        run(10);
        check_eq("t2_nreq", 32'(req_log.size()), 32'h2);
        check_eq("t2_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("t2_inst_valid", 32'(inst_valid), 32'h1);
        check_eq("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        run(10);
        check_eq("t2_resume_addr", at(req_log, 2), 32'h8);
        check_eq("t2_pc0", at(pop_log, 0), 32'h0);
        check_eq("t2_pc1", at(pop_log, 1), 32'h4);
        check_eq("t2_pc2", at(pop_log, 2), 32'h8);

        // Redirect with two stale requests, latency 3
        assert_reset();
        lat = 3;
        release_reset();
        wait_two_outstanding("t3_outstanding");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check_eq("t3_flush_inst_valid", 32'(inst_valid), 32'h0);
        np = pop_log.size();
        nr = req_log.size();
        run(20);
        check_eq("t3_first_req", at(req_log, nr), 32'h100);
        check_eq("t3_first_pc", at(pop_log, np), 32'h100);
        check_eq("t3_second_pc", at(pop_log, np + 1), 32'h104);

        // Redirect coinciding with a response and a pop
        assert_reset();
        lat = 1;
        release_reset();
        for (int i = 0; i < 20; i++) begin
            if (inst_valid && imem_rsp_valid) break;
            step();
        end
        check_eq("t4_coincide", 32'(inst_valid & imem_rsp_valid), 32'h1);
        np = pop_log.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check_eq("t4_pop_done", 32'(pop_log.size()), 32'(np + 1));
        check_eq("t4_flush_inst_valid", 32'(inst_valid), 32'h0);
        np = pop_log.size();
        run(15);
        check_eq("t4_first_pc", at(pop_log, np), 32'h200);

        // Misaligned redirect target
        assert_reset();
        lat = 2;
        release_reset();
        run(6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        check_eq("t5_flush_inst_valid", 32'(inst_valid), 32'h0);
        np = pop_log.size();
        nr = req_log.size();
        run(15);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("t5_misaligned", 32'(fetch_misaligned), 32'h1);
        check_eq("t5_no_new_req", 32'(req_log.size()), 32'(nr));
        check_eq("t5_halt_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("t5_halt_inst_valid", 32'(inst_valid), 32'h0);
`else
        check_eq("t5_misaligned", 32'(fetch_misaligned), 32'h0);
        check_eq("t5_first_req", at(req_log, nr), 32'h100);
        check_eq("t5_first_pc", at(pop_log, np), 32'h100);
`endif

        // Asynchronous reset with requests in flight
        assert_reset();
        lat = 3;
        release_reset();
        wait_two_outstanding("t6_outstanding");
        #2;
        assert_reset();
        #1;
        check_reset_outputs("t6_async");
        release_reset();
        run(10);
        check_eq("t6_first_pc", at(pop_log, 0), 32'h0);
        check_eq("t6_second_pc", at(pop_log, 1), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
